mem_arbiter: RTL and testbench

- Two-master arbiter in front of ssram_ctrl; replaces the combinational fb/yari mux in the top level.
- Shares one mem_* port between the yari CPU master and the video framebuffer (FB) read master.
- FB has priority, bounded by a starvation limit.
- A granted request stays locked to its master until the controller accepts it, so Avalon-style hold rules are never violated.

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (yari CPU / framebuffer read) arbiter in front of ssram_ctrl; FB priority with a CPU starvation limit.
// Latency: zero - an uncontended request reaches mem_* and can be accepted in the cycle it is presented.
// Backpressure: mem_waitrequest stalls the granted master; the loser always sees waitrequest. Optional stats: MEM_ARB_STATS_EN.
module mem_arbiter #(
   parameter logic [1:0] ID_FB         = 2'd3,
   parameter int         FB_MAX_STREAK = 4,
   parameter int         STREAK_W      = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  cpu_id,
   input  logic [29:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_writedata,
   input  logic [3:0]  cpu_writedatamask,
   output logic        cpu_waitrequest,
   input  logic [29:0] fb_address,
   input  logic        fb_read,
   output logic        fb_waitrequest,
   output logic        fb_readdatavalid,
   output logic [1:0]  mem_id,
   output logic [29:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_writedatamask,
   input  logic        mem_waitrequest,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0] stat_fb_accepts,
   output logic [31:0] stat_cpu_accepts,
   output logic [31:0] stat_cpu_stall_cycles,
`endif
   input  logic [1:0]  mem_readdataid
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FB_MAX_STREAK);

   logic                lock_q, lock_d;
   logic                owner_q, owner_d;   // 0 = CPU, 1 = FB
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic cpu_req;
   logic grant_vld;
   logic grant_fb;
   logic mem_req;
   logic accept;

   assign cpu_req = cpu_read | cpu_write;

   // Grant selection: a lock pins the owner until accept, otherwise FB wins unless the CPU has starved long enough
   always_comb begin
      grant_vld = 1'b0;
      grant_fb  = 1'b0;
      if (lock_q) begin
         grant_vld = 1'b1;
         grant_fb  = owner_q;
      end else if (fb_read && cpu_req && (streak_q >= STREAK_MAX)) begin
         grant_vld = 1'b1;
         grant_fb  = 1'b0;
      end else if (fb_read) begin
         grant_vld = 1'b1;
         grant_fb  = 1'b1;
      end else if (cpu_req) begin
         grant_vld = 1'b1;
         grant_fb  = 1'b0;
      end
   end

   // Request mux: FB is read-only; with no grant the fields default to the CPU side with the strobes low
   always_comb begin
      mem_id            = cpu_id;
      mem_address       = cpu_address;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      mem_writedata     = cpu_writedata;
      mem_writedatamask = cpu_writedatamask;
      if (grant_fb) begin
         mem_id      = ID_FB;
         mem_address = fb_address;
      end
      if (grant_vld && !reset) begin
         mem_read  = grant_fb ? 1'b1 : cpu_read;
         mem_write = grant_fb ? 1'b0 : cpu_write;
      end
   end

   assign mem_req = mem_read | mem_write;
   assign accept  = mem_req & ~mem_waitrequest;

   assign cpu_waitrequest  = reset | mem_waitrequest | ~(grant_vld & ~grant_fb);
   assign fb_waitrequest   = reset | mem_waitrequest | ~(grant_vld &  grant_fb);
   assign fb_readdatavalid = (mem_readdataid == ID_FB);

   // Next lock/owner/streak: lock a stalled grant, release on accept; streak counts FB wins over a waiting CPU
   always_comb begin
      lock_d   = 1'b0;
      owner_d  = owner_q;
      streak_d = streak_q;
      if (mem_req && mem_waitrequest) begin
         lock_d  = 1'b1;
         owner_d = grant_fb;
      end
      if (!cpu_req || (accept && !grant_fb)) begin
         streak_d = '0;
      end else if (accept && grant_fb && (streak_q < STREAK_MAX)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   // State register with synchronous reset; masters must re-present after a reset
   always_ff @(posedge clock) begin
      if (reset) begin
         lock_q   <= 1'b0;
         owner_q  <= 1'b0;
         streak_q <= '0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   // Free-running wrap-around event counters for accepts and CPU stall cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_fb_accepts       <= '0;
         stat_cpu_accepts      <= '0;
         stat_cpu_stall_cycles <= '0;
      end else begin
         if (accept && grant_fb)        stat_fb_accepts       <= stat_fb_accepts + 32'd1;
         if (accept && !grant_fb)       stat_cpu_accepts      <= stat_cpu_accepts + 32'd1;
         if (cpu_req && cpu_waitrequest) stat_cpu_stall_cycles <= stat_cpu_stall_cycles + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   // The CPU must never borrow the FB return ID, or its read data would be claimed by the framebuffer
   a_cpu_id: assert property (@(posedge clock) disable iff (reset) cpu_req |-> (cpu_id != ID_FB))
      else $error("mem_arbiter: cpu_id equals ID_FB while CPU requests");
   // A locked owner has to hold its request until the controller takes it
   a_hold: assert property (@(posedge clock) disable iff (reset) lock_q |-> (owner_q ? fb_read : cpu_req))
      else $error("mem_arbiter: locked owner dropped its request before accept");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for grant/mux/streak, hand sequences for lock and reset corners.
// Each step drives inputs, checks combinational outputs mid-cycle, then advances one rising edge.
// Summary line reports comparison and failure counts.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  cpu_id;
   logic [29:0] cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [3:0]  cpu_writedatamask;
   logic        cpu_waitrequest;
   logic [29:0] fb_address;
   logic        fb_read;
   logic        fb_waitrequest;
   logic        fb_readdatavalid;
   logic [1:0]  mem_id;
   logic [29:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_writedatamask;
   logic        mem_waitrequest;
   logic [1:0]  mem_readdataid;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_fb_accepts;
   logic [31:0] stat_cpu_accepts;
   logic [31:0] stat_cpu_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .cpu_id            (cpu_id),
      .cpu_address       (cpu_address),
      .cpu_read          (cpu_read),
      .cpu_write         (cpu_write),
      .cpu_writedata     (cpu_writedata),
      .cpu_writedatamask (cpu_writedatamask),
      .cpu_waitrequest   (cpu_waitrequest),
      .fb_address        (fb_address),
      .fb_read           (fb_read),
      .fb_waitrequest    (fb_waitrequest),
      .fb_readdatavalid  (fb_readdatavalid),
      .mem_id            (mem_id),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_writedatamask (mem_writedatamask),
      .mem_waitrequest   (mem_waitrequest),
`ifdef MEM_ARB_STATS_EN
      .stat_fb_accepts       (stat_fb_accepts),
      .stat_cpu_accepts      (stat_cpu_accepts),
      .stat_cpu_stall_cycles (stat_cpu_stall_cycles),
`endif
      .mem_readdataid    (mem_readdataid)
   );

   typedef struct {
      logic        rst;
      logic        crd;
      logic        cwr;
      logic [1:0]  cid;
      logic [29:0] caddr;
      logic        frd;
      logic        wreq;
      logic [1:0]  rdid;
      logic        chk_mux;
      logic        e_rd;
      logic        e_wr;
      logic [1:0]  e_id;
      logic [29:0] e_addr;
      logic        e_cw;
      logic        e_fw;
      logic        e_fv;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic crd, input logic cwr, input logic [1:0] cid,
                               input logic [29:0] caddr, input logic frd, input logic wreq,
                               input logic [1:0] rdid, input logic chk_mux, input logic e_rd,
                               input logic e_wr, input logic [1:0] e_id, input logic [29:0] e_addr,
                               input logic e_cw, input logic e_fw, input logic e_fv);
      vec_t v;
      v.rst = rst; v.crd = crd; v.cwr = cwr; v.cid = cid; v.caddr = caddr; v.frd = frd;
      v.wreq = wreq; v.rdid = rdid; v.chk_mux = chk_mux; v.e_rd = e_rd; v.e_wr = e_wr;
      v.e_id = e_id; v.e_addr = e_addr; v.e_cw = e_cw; v.e_fw = e_fw; v.e_fv = e_fv;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   localparam logic [29:0] FB_ADDR = 30'h2000;

   initial begin
      reset = 1'b1; cpu_id = 2'd1; cpu_address = 30'h100; cpu_read = 0; cpu_write = 0;
      cpu_writedata = 32'h1234_5678; cpu_writedatamask = 4'hF; fb_address = FB_ADDR;
      fb_read = 0; mem_waitrequest = 0; mem_readdataid = 2'd0;

      //            rst crd cwr cid  caddr    frd w  rdid chk rd wr id  addr     cw fw fv
      vecs.push_back(mk(1, 1, 0, 2'd1, 30'h100, 1, 0, 2'd0, 0, 0, 0, 2'd0, 30'h0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 2'd1, 30'h100, 1, 0, 2'd0, 0, 0, 0, 2'd0, 30'h0, 1, 1, 0));
      // idle: no strobes, mux defaults to the CPU fields
      vecs.push_back(mk(0, 0, 0, 2'd1, 30'h100, 0, 0, 2'd0, 1, 0, 0, 2'd1, 30'h100, 1, 1, 0));
      // lone CPU read accepted in the same cycle
      vecs.push_back(mk(0, 1, 0, 2'd1, 30'h100, 0, 0, 2'd0, 1, 1, 0, 2'd1, 30'h100, 0, 1, 0));
      // simultaneous CPU and FB with streak 0: FB wins
      vecs.push_back(mk(0, 1, 0, 2'd1, 30'h100, 1, 0, 2'd0, 1, 1, 0, 2'd3, FB_ADDR, 1, 0, 0));
      // reset with nothing pending: clears streak and statistics
      vecs.push_back(mk(1, 0, 0, 2'd1, 30'h100, 0, 0, 2'd0, 0, 0, 0, 2'd0, 30'h0, 1, 1, 0));
      // contention: FB read vs CPU write, 4 FB accepts then 1 CPU, twice
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 0, 1, 2'd2, 30'h300, 1, 0, 2'd0, 1, 1, 0, 2'd3, FB_ADDR, 1, 0, 0));
         vecs.push_back(mk(0, 0, 1, 2'd2, 30'h300, 1, 0, 2'd0, 1, 0, 1, 2'd2, 30'h300, 0, 1, 0));
      end
      // FB resumes after the forced CPU slot (streak back to 0)
      vecs.push_back(mk(0, 0, 1, 2'd2, 30'h300, 1, 0, 2'd0, 1, 1, 0, 2'd3, FB_ADDR, 1, 0, 0));
      // return-ID decode
      vecs.push_back(mk(0, 0, 0, 2'd1, 30'h100, 0, 0, 2'd3, 1, 0, 0, 2'd1, 30'h100, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 2'd1, 30'h100, 0, 0, 2'd1, 1, 0, 0, 2'd1, 30'h100, 1, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; cpu_read = vecs[i].crd; cpu_write = vecs[i].cwr;
         cpu_id = vecs[i].cid; cpu_address = vecs[i].caddr; fb_read = vecs[i].frd;
         mem_waitrequest = vecs[i].wreq; mem_readdataid = vecs[i].rdid;
         #2;
         chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
         chk($sformatf("v%0d cpu_wait", i), 32'(cpu_waitrequest), 32'(vecs[i].e_cw));
         chk($sformatf("v%0d fb_wait", i), 32'(fb_waitrequest), 32'(vecs[i].e_fw));
         chk($sformatf("v%0d fb_rdv", i), 32'(fb_readdatavalid), 32'(vecs[i].e_fv));
         if (vecs[i].chk_mux) begin
            chk($sformatf("v%0d mem_id", i), 32'(mem_id), 32'(vecs[i].e_id));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
         end
         tick();
`ifdef MEM_ARB_STATS_EN
         if (i == 15) begin
            chk("stat_fb", stat_fb_accepts, 32'd8);
            chk("stat_cpu", stat_cpu_accepts, 32'd2);
            chk("stat_stall", stat_cpu_stall_cycles, 32'd8);
         end
`endif
      end

      // Lock hold: CPU write stalled 3 cycles while FB starts requesting
      cpu_read = 0; cpu_write = 0; fb_read = 0; mem_readdataid = 0; mem_waitrequest = 0;
      tick();
      cpu_write = 1; cpu_id = 2'd1; cpu_address = 30'h444; cpu_writedata = 32'hDEAD_BEEF;
      cpu_writedatamask = 4'hA; mem_waitrequest = 1;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("lock c%0d mem_write", c), 32'(mem_write), 32'd1);
         chk($sformatf("lock c%0d mem_read", c), 32'(mem_read), 32'd0);
         chk($sformatf("lock c%0d mem_addr", c), 32'(mem_address), 32'h444);
         chk($sformatf("lock c%0d mem_id", c), 32'(mem_id), 32'd1);
         chk($sformatf("lock c%0d wdata", c), mem_writedata, 32'hDEAD_BEEF);
         chk($sformatf("lock c%0d wmask", c), 32'(mem_writedatamask), 32'hA);
         chk($sformatf("lock c%0d fb_wait", c), 32'(fb_waitrequest), 32'd1);
         tick();
         fb_read = 1;
      end
      mem_waitrequest = 0;
      #2;
      chk("lock accept mem_write", 32'(mem_write), 32'd1);
      chk("lock accept cpu_wait", 32'(cpu_waitrequest), 32'd0);
      chk("lock accept fb_wait", 32'(fb_waitrequest), 32'd1);
      tick();
      cpu_write = 0;
      #2;
      chk("after lock fb grant mem_read", 32'(mem_read), 32'd1);
      chk("after lock fb grant mem_id", 32'(mem_id), 32'd3);
      chk("after lock fb grant fb_wait", 32'(fb_waitrequest), 32'd0);
      tick();

      // Reset while FB holds the lock
      fb_read = 1; mem_waitrequest = 1;
      #2;
      chk("rst-lock fb grant", 32'(mem_read), 32'd1);
      tick();
      reset = 1;
      #2;
      chk("in reset mem_read", 32'(mem_read), 32'd0);
      chk("in reset fb_wait", 32'(fb_waitrequest), 32'd1);
      chk("in reset cpu_wait", 32'(cpu_waitrequest), 32'd1);
      tick();
      reset = 0; fb_read = 0; cpu_read = 1; cpu_address = 30'h100; mem_waitrequest = 1;
      #2;
      chk("post reset cpu grant mem_read", 32'(mem_read), 32'd1);
      chk("post reset cpu grant mem_addr", 32'(mem_address), 32'h100);
      chk("post reset cpu grant mem_id", 32'(mem_id), 32'd1);
      tick();
      mem_waitrequest = 0;
      #2;
      chk("post reset cpu accept", 32'(cpu_waitrequest), 32'd0);
      tick();
      cpu_read = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
